macro_wb_sched: RTL

//  Wishbone scheduler between the SoC user-area slave port and NUM_MACROS tile macros.
//  - Decodes a slot index from the address and forwards one transaction at a time to the selected macro.
//  - Bounds each access with a timeout; unpopulated or non-acking macros can never hang the bus.
//  - Holds a control/status register slot that selects which macro owns the shared pad ring (io_owner_o).

---
 rtl/macro_wb_sched.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/macro_wb_sched.sv
// Wishbone scheduler: forwards one user-area transaction at a time to a tile macro,
// bounds every access with a timeout and owns the pad-ring control/status registers.
module macro_wb_sched #(
  parameter int unsigned NUM_MACROS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter logic [7:0]  BASE_ADDR  = 8'h30,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic [NUM_MACROS-1:0]      m_cyc_o,
  output logic [NUM_MACROS-1:0]      m_stb_o,
  output logic                       m_we_o,
  output logic [3:0]                 m_sel_o,
  output logic [31:0]                m_adr_o,
  output logic [31:0]                m_dat_o,
  input  logic [NUM_MACROS-1:0]      m_ack_i,
  input  logic [32*NUM_MACROS-1:0]   m_dat_i,
  output logic [IDX_W-1:0]           io_owner_o,
  output logic                       io_en_o,
  output logic                       irq_o
);

  localparam logic [3:0]  CSR_SLOT = 4'(NUM_MACROS);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [3:0]            slot;
  logic                  hit, req, is_macro, is_csr;
  logic                  abort, got_ack, tmo;
  logic [NUM_MACROS-1:0] slot_onehot;
  logic [NUM_MACROS-1:0] m_cyc_q;
  logic [31:0]           ack_data, ctrl_val, csr_rdata;
  logic [IDX_W-1:0]      owner_in, owner_clamped;

  logic [3:0]            cur_slot;
  logic [15:0]           timer;
  logic [31:0]           resp_data;
  logic                  csr_pend;
  logic [1:0]            csr_addr;
  logic                  csr_wr_owner, csr_wr_en, csr_clr_to, csr_en_val;
  logic [IDX_W-1:0]      csr_owner_val;
  logic                  status_to;
  logic [3:0]            last_slot;
  logic [15:0]           to_cnt;

  assign slot     = wbs_adr_i[23:20];
  assign hit      = (wbs_adr_i[31:24] == BASE_ADDR);
  assign is_macro = hit && (slot < CSR_SLOT);
  assign is_csr   = hit && (slot == CSR_SLOT);
  // The ack check keeps a still-asserted strobe from being taken as a second request.
  assign req      = (state == IDLE) && wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign abort    = !wbs_cyc_i;
  assign got_ack  = |(m_ack_i & m_cyc_q);
  assign tmo      = (timer == TO_LAST);

  assign owner_in      = wbs_dat_i[IDX_W-1:0];
  assign owner_clamped = (32'(owner_in) >= NUM_MACROS) ? '0 : owner_in;

  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_cyc_q;
  assign irq_o   = status_to;

  always_comb begin
    slot_onehot = '0;
    ack_data    = '0;
    for (int k = 0; k < int'(NUM_MACROS); k++) begin
      slot_onehot[k] = (slot == 4'(k));
      if (m_cyc_q[k]) ack_data = m_dat_i[32*k +: 32];
    end
  end

  always_comb begin
    ctrl_val             = '0;
    ctrl_val[IDX_W-1:0]  = io_owner_o;
    ctrl_val[8]          = io_en_o;
    case (csr_addr)
      2'd0:    csr_rdata = ctrl_val;
      2'd1:    csr_rdata = {20'h0, last_slot, 7'h0, status_to};
      2'd2:    csr_rdata = {16'h0, to_cnt};
      default: csr_rdata = {16'h4D53, 8'h00, 8'(NUM_MACROS)};
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = is_macro ? ACCESS : RESP;
      ACCESS: begin
        if (abort)               state_nxt = IDLE;
        else if (got_ack || tmo) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CSR writes are decoded at accept and applied on the edge that raises the ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o     <= 1'b0;
      wbs_dat_o     <= '0;
      m_cyc_q       <= '0;
      m_we_o        <= 1'b0;
      m_sel_o       <= '0;
      m_adr_o       <= '0;
      m_dat_o       <= '0;
      io_owner_o    <= '0;
      io_en_o       <= 1'b0;
      cur_slot      <= '0;
      timer         <= '0;
      resp_data     <= '0;
      csr_pend      <= 1'b0;
      csr_addr      <= '0;
      csr_wr_owner  <= 1'b0;
      csr_wr_en     <= 1'b0;
      csr_clr_to    <= 1'b0;
      csr_en_val    <= 1'b0;
      csr_owner_val <= '0;
      status_to     <= 1'b0;
      last_slot     <= '0;
      to_cnt        <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            csr_pend <= is_csr;
            if (is_macro) begin
              m_cyc_q  <= slot_onehot;
              m_we_o   <= wbs_we_i;
              m_sel_o  <= wbs_sel_i;
              m_adr_o  <= {12'h0, wbs_adr_i[19:0]};
              m_dat_o  <= wbs_dat_i;
              cur_slot <= slot;
              timer    <= '0;
            end else if (is_csr) begin
              csr_addr      <= wbs_adr_i[3:2];
              csr_wr_owner  <= wbs_we_i && (wbs_adr_i[3:2] == 2'd0) && wbs_sel_i[0];
              csr_wr_en     <= wbs_we_i && (wbs_adr_i[3:2] == 2'd0) && wbs_sel_i[1];
              csr_clr_to    <= wbs_we_i && (wbs_adr_i[3:2] == 2'd1) && wbs_sel_i[0] && wbs_dat_i[0];
              csr_owner_val <= owner_clamped;
              csr_en_val    <= wbs_dat_i[8];
            end else begin
              resp_data <= 32'hDEAD_0001;
            end
          end
        end
        ACCESS: begin
          if (abort) begin
            m_cyc_q <= '0;
          end else if (got_ack) begin
            m_cyc_q   <= '0;
            resp_data <= ack_data;
          end else if (tmo) begin
            m_cyc_q   <= '0;
            resp_data <= 32'hDEAD_BEEF;
            status_to <= 1'b1;
            last_slot <= cur_slot;
            if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= csr_pend ? csr_rdata : resp_data;
          if (csr_pend) begin
            if (csr_wr_owner) io_owner_o <= csr_owner_val;
            if (csr_wr_en)    io_en_o    <= csr_en_val;
            if (csr_clr_to)   status_to  <= 1'b0;
          end
          csr_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
